// File: rtl/flash_sr_responder_if.sv
// SPI pin bundle between a flash-lock initiator (master) and the status-register responder (slave).
interface flash_sr_responder_if;
    logic spi_clk;
    logic spi_mosi;
    logic spi_cs_n;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_clk,
        output spi_mosi,
        output spi_cs_n,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_clk,
        input  spi_mosi,
        input  spi_cs_n,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/flash_sr_responder.sv
// SPI mode-0 responder emulating a NOR flash status register (WREN/WRDI/RDSR/WRSR), oversampled on clk.
// Define FLASH_SR_RESP_SR2_EN to add SR2 storage, RDSR2 (0x35), WRSR2 (0x31) and 2-byte WRSR.
module flash_sr_responder #(
    parameter logic [7:0] SR1_INIT    = 8'h00,
    parameter logic [7:0] SR2_INIT    = 8'h00,
    parameter int         BUSY_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    flash_sr_responder_if.slave        spi,
    output logic [7:0]                 sr1,
    output logic [7:0]                 sr2,
    output logic                       sr_wr_stb,
    output logic                       busy
);

    localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    localparam logic [7:0] OP_WRSR = 8'h01;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
`ifdef FLASH_SR_RESP_SR2_EN
    localparam logic [7:0] OP_WRSR2 = 8'h31;
    localparam logic [7:0] OP_RDSR2 = 8'h35;
    localparam int         D1_LSB   = 0;
`else
    localparam int         D1_LSB   = 2;
`endif

    typedef enum logic [2:0] {IDLE, CMD, RD, WR, IGN} state_t;
    state_t state, state_next;

    logic [2:0]       sck_s, cs_s;
    logic [1:0]       mosi_s;
    logic             sck_rise, sck_fall, cs_rise, cs_fall, mosi_bit;
    logic [2:0]       bit_cnt;
    logic [1:0]       byte_cnt;
    logic [6:0]       rx_shift;
    logic [7:0]       byte_in, op, tx_shift, rd_live;
    logic             rd_fresh;
    logic [7:D1_LSB]  data1;
    logic [7:2]       sr1_hi;
    logic             wel, wip;
    logic [CNT_W-1:0] busy_cnt;
    logic             cmd_done, rd_start, frame_ok, wel_set, wel_clr, commit;
`ifdef FLASH_SR_RESP_SR2_EN
    logic [7:0]       data2, sr2_q, rd_op;
`endif

    // Chip-select stages reset low so a CS already low at reset release never looks like a fresh fall
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s  <= 3'b000;
            cs_s   <= 3'b000;
            mosi_s <= 2'b00;
        end else begin
            sck_s  <= {sck_s[1:0], spi.spi_clk};
            cs_s   <= {cs_s[1:0], spi.spi_cs_n};
            mosi_s <= {mosi_s[0], spi.spi_mosi};
        end
    end

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign sck_fall = ~sck_s[1] & sck_s[2];
    assign cs_rise  = cs_s[1] & ~cs_s[2];
    assign cs_fall  = ~cs_s[1] & cs_s[2];
    assign mosi_bit = mosi_s[1];
    assign byte_in  = {rx_shift, mosi_bit};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_done   = (state == CMD) && sck_rise && (bit_cnt == 3'd7);
        frame_ok   = cs_rise && (bit_cnt == 3'd0);
        wel_set    = 1'b0;
        wel_clr    = 1'b0;
        commit     = 1'b0;
        if (cs_rise) begin
            state_next = IDLE;
        end else if (cs_fall) begin
            state_next = CMD;
        end else if (cmd_done) begin
            case (byte_in)
                OP_RDSR:  state_next = RD;
                OP_WRSR:  state_next = WR;
`ifdef FLASH_SR_RESP_SR2_EN
                OP_RDSR2: state_next = RD;
                OP_WRSR2: state_next = WR;
`endif
                default:  state_next = IGN;
            endcase
        end
        rd_start = cmd_done && (state_next == RD);
        // WREN/WRDI only count for a frame of exactly the opcode byte
        if (frame_ok && !wip) begin
            if (state == IGN && byte_cnt == 2'd0) begin
                wel_set = (op == OP_WREN);
                wel_clr = (op == OP_WRDI);
            end
            if (state == WR && byte_cnt != 2'd0 && wel) commit = 1'b1;
        end
    end

`ifdef FLASH_SR_RESP_SR2_EN
    always_comb begin
        rd_op   = (state == CMD) ? byte_in : op;
        rd_live = (rd_op == OP_RDSR2) ? sr2_q : sr1;
    end
`else
    assign rd_live = sr1;
`endif

    // First read byte is latched at decode and held through that byte's trailing SCK fall
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_shift <= '0;
            op       <= '0;
            data1    <= '0;
            tx_shift <= '0;
            rd_fresh <= 1'b0;
`ifdef FLASH_SR_RESP_SR2_EN
            data2    <= '0;
`endif
        end else if (cs_fall) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rd_fresh <= 1'b0;
        end else if (state != IDLE) begin
            if (sck_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= byte_in[6:0];
                if (cmd_done) op <= byte_in;
                if (state != CMD && bit_cnt == 3'd7) begin
                    if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
                    if (state == WR && byte_cnt == 2'd0) data1 <= byte_in[7:D1_LSB];
`ifdef FLASH_SR_RESP_SR2_EN
                    if (state == WR && byte_cnt == 2'd1) data2 <= byte_in;
`endif
                end
            end
            if (rd_start) begin
                tx_shift <= rd_live;
                rd_fresh <= 1'b1;
            end else if (state == RD && sck_fall) begin
                if (rd_fresh)             rd_fresh <= 1'b0;
                else if (bit_cnt == 3'd0) tx_shift <= rd_live;
                else                      tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr1_hi    <= SR1_INIT[7:2];
            wel       <= 1'b0;
            wip       <= 1'b0;
            busy_cnt  <= '0;
            sr_wr_stb <= 1'b0;
        end else begin
            sr_wr_stb <= commit;
            if (commit) begin
                if (op == OP_WRSR) sr1_hi <= data1[7:2];
                wel      <= 1'b0;
                wip      <= 1'b1;
                busy_cnt <= CNT_W'(BUSY_CYCLES - 1);
            end else begin
                if (wel_set)      wel <= 1'b1;
                else if (wel_clr) wel <= 1'b0;
                if (wip) begin
                    if (busy_cnt == '0) wip <= 1'b0;
                    else                busy_cnt <= busy_cnt - 1'b1;
                end
            end
        end
    end

`ifdef FLASH_SR_RESP_SR2_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sr2_q <= SR2_INIT;
        end else if (commit) begin
            if (op == OP_WRSR2)        sr2_q <= data1;
            else if (byte_cnt >= 2'd2) sr2_q <= data2;
        end
    end
    assign sr2 = sr2_q;
`else
    // SR2_INIT only matters in SR2 builds; masked to keep sr2 at zero here
    assign sr2 = SR2_INIT & 8'h00;
`endif

    assign sr1             = {sr1_hi, wel, wip};
    assign busy            = wip;
    assign spi.spi_miso    = (state == RD) ? tx_shift[7] : 1'b0;
    assign spi.spi_miso_oe = (state == RD);

endmodule

// File: tb/tb_flash_sr_responder.sv
// Directed bench for flash_sr_responder: drives SPI mode-0 frames and checks status-register behaviour.
module tb_flash_sr_responder;

    localparam int BUSY = 200;
    localparam int HALF = 8;
`ifdef FLASH_SR_RESP_SR2_EN
    localparam logic [7:0] SR2_RST = 8'h5A;
`else
    localparam logic [7:0] SR2_RST = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sr1, sr2;
    logic       sr_wr_stb, busy;

    int compared   = 0;
    int mismatched = 0;
    int stb_seen   = 0;
    int busy_seen  = 0;
    int stb0, busy0;

    logic [31:0] rx_word;
    logic        oe_cmd, oe_any, oe_all;

    always #5 clk = ~clk;

    flash_sr_responder_if spi_bus();

    flash_sr_responder #(
        .SR1_INIT    (8'h03),
        .SR2_INIT    (8'h5A),
        .BUSY_CYCLES (BUSY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi_bus),
        .sr1       (sr1),
        .sr2       (sr2),
        .sr_wr_stb (sr_wr_stb),
        .busy      (busy)
    );

    // Count strobe pulses and busy cycles so tests can take before/after deltas
    always @(negedge clk) begin
        if (sr_wr_stb) stb_seen++;
        if (busy) busy_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CS-framed transfer of nbits, MSB of tx first; MISO is sampled at each SCK rise
    task automatic applyStimulus(input logic [31:0] tx, input int nbits);
        rx_word = '0;
        oe_cmd  = 1'b0;
        oe_any  = 1'b0;
        oe_all  = 1'b1;
        spi_bus.spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_bus.spi_mosi = tx[31-i];
            repeat (HALF) @(negedge clk);
            spi_bus.spi_clk = 1'b1;
            rx_word = {rx_word[30:0], spi_bus.spi_miso};
            if (i < 8) begin
                oe_cmd = oe_cmd | spi_bus.spi_miso_oe;
            end else begin
                oe_any = oe_any | spi_bus.spi_miso_oe;
                oe_all = oe_all & spi_bus.spi_miso_oe;
            end
            repeat (HALF) @(negedge clk);
            spi_bus.spi_clk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_bus.spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
        checkOutput("busy_drop", busy, 1'b0);
    endtask

    initial begin
        spi_bus.spi_clk  = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        spi_bus.spi_cs_n = 1'b1;
        doReset();

        // Reset state; SR1_INIT low bits must not leak into WEL/WIP
        checkOutput("rst_sr1", sr1, 8'h00);
        checkOutput("rst_sr2", sr2, SR2_RST);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_stb", sr_wr_stb, 1'b0);
        checkOutput("rst_oe", spi_bus.spi_miso_oe, 1'b0);
        checkOutput("rst_miso", spi_bus.spi_miso, 1'b0);

        // RDSR over two bytes after reset
        applyStimulus(32'h0500_0000, 24);
        checkOutput("t1_rdsr", rx_word[15:0], 16'h0000);
        checkOutput("t1_oe_cmd", oe_cmd, 1'b0);
        checkOutput("t1_oe_data", oe_all, 1'b1);
        checkOutput("t1_oe_after", spi_bus.spi_miso_oe, 1'b0);

        // WREN, WRSR commit, then WIP falls between the two streamed bytes
        applyStimulus(32'h0600_0000, 8);
        applyStimulus(32'h0500_0000, 16);
        checkOutput("t2_wel", rx_word[7:0], 8'h02);
        stb0  = stb_seen;
        busy0 = busy_seen;
        applyStimulus(32'h011C_0000, 16);
        checkOutput("t2_sr1_commit", sr1, 8'h1D);
        applyStimulus(32'h0500_0000, 24);
        checkOutput("t2_rdsr_poll", rx_word[15:0], 16'h1D1C);
        waitIdle();
        checkOutput("t2_stb", stb_seen - stb0, 1);
        checkOutput("t2_busy_len", busy_seen - busy0, BUSY);
        applyStimulus(32'h0500_0000, 16);
        checkOutput("t2_rdsr_done", rx_word[7:0], 8'h1C);

        // WRSR without WREN
        doReset();
        stb0 = stb_seen;
        applyStimulus(32'h011C_0000, 16);
        checkOutput("t3_sr1", sr1, 8'h00);
        checkOutput("t3_stb", stb_seen - stb0, 0);

        // WRSR aborted after 5 data bits
        applyStimulus(32'h0600_0000, 8);
        applyStimulus(32'h011C_0000, 13);
        checkOutput("t4_sr1", sr1, 8'h02);
        checkOutput("t4_stb", stb_seen - stb0, 0);

        // Unknown opcode 9F
        applyStimulus(32'h9F00_0000, 24);
        checkOutput("t5_oe", oe_any | oe_cmd, 1'b0);
        checkOutput("t5_sr1", sr1, 8'h02);

        // WRDI, and WREN frames that are not exactly 8 bits
        applyStimulus(32'h0400_0000, 8);
        checkOutput("wrdi_sr1", sr1, 8'h00);
        applyStimulus(32'h0600_0000, 9);
        checkOutput("wren9_sr1", sr1, 8'h00);
        applyStimulus(32'h0600_0000, 16);
        checkOutput("wren16_sr1", sr1, 8'h00);

        // WREN ignored while busy
        applyStimulus(32'h0600_0000, 8);
        applyStimulus(32'h0180_0000, 16);
        checkOutput("busy_sr1", sr1, 8'h81);
        applyStimulus(32'h0600_0000, 8);
        checkOutput("busy_wren", sr1, 8'h81);
        waitIdle();
        checkOutput("busy_after", sr1, 8'h80);

        // Reset while a busy count is pending
        applyStimulus(32'h0600_0000, 8);
        applyStimulus(32'h0140_0000, 16);
        checkOutput("rstmid_pre", sr1, 8'h41);
        doReset();
        checkOutput("rstmid_sr1", sr1, 8'h00);
        checkOutput("rstmid_busy", busy, 1'b0);
        checkOutput("rstmid_sr2", sr2, SR2_RST);

`ifdef FLASH_SR_RESP_SR2_EN
        // Two-byte WRSR, RDSR2, then WRSR2
        applyStimulus(32'h0600_0000, 8);
        applyStimulus(32'h011C_0200, 24);
        checkOutput("sr2_sr1", sr1, 8'h1D);
        checkOutput("sr2_sr2", sr2, 8'h02);
        applyStimulus(32'h3500_0000, 16);
        checkOutput("sr2_rdsr2", rx_word[7:0], 8'h02);
        checkOutput("sr2_rdsr2_oe", oe_all, 1'b1);
        waitIdle();
        applyStimulus(32'h0600_0000, 8);
        applyStimulus(32'h31A5_0000, 16);
        checkOutput("sr2_wrsr2_sr2", sr2, 8'hA5);
        checkOutput("sr2_wrsr2_sr1", sr1, 8'h1D);
        waitIdle();
`else
        // Without SR2: 0x35 is unknown and a second WRSR byte is ignored
        applyStimulus(32'h0600_0000, 8);
        applyStimulus(32'h3500_0000, 16);
        checkOutput("nosr2_rdsr2_oe", oe_any | oe_cmd, 1'b0);
        checkOutput("nosr2_wel", sr1, 8'h02);
        applyStimulus(32'h011C_0200, 24);
        checkOutput("nosr2_sr1", sr1, 8'h1D);
        checkOutput("nosr2_sr2", sr2, 8'h00);
        waitIdle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
